// File: rtl/length_pkg.sv
// Shared constants, frame FSM state type and digit sanitising helper for the
// distance-frame UART transmitter.
package length_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_C     = 8'h63;
    localparam logic [7:0] ASCII_M     = 8'h6D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int FRAME_LEN  = 10;
    localparam int NUM_DIGITS = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } frame_state_e;

    // Anything that is not an ASCII decimal digit goes out as '0'.
    function automatic logic [7:0] sanitize(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? c : ASCII_ZERO;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 single-character transmitter: start bit, 8 data bits LSB first, stop bit,
// every bit held BAUD_DIV clocks. done pulses once after the stop bit ends.
module uart_byte_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       ready,
    output logic       done
);

    localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] baud_q;
    logic [3:0]    bit_q;
    logic [7:0]    sh_q;
    logic          active_q;
    logic          txd_q;
    logic          done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            active_q <= 1'b0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (start) begin
                    active_q <= 1'b1;
                    txd_q    <= 1'b0;
                    baud_q   <= '0;
                    bit_q    <= '0;
                    sh_q     <= data;
                end
            end else if (baud_q == BAUD_LAST) begin
                baud_q <= '0;
                if (bit_q == 4'd9) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    // Ones shift in behind the data, so bit 9 comes out as the stop bit.
                    bit_q <= bit_q + 4'd1;
                    txd_q <= sh_q[0];
                    sh_q  <= {1'b1, sh_q[7:1]};
                end
            end else begin
                baud_q <= baud_q + 1'b1;
            end
        end
    end

    assign txd   = txd_q;
    assign ready = !active_q;
    assign done  = done_q;

endmodule

// File: rtl/length_uart_tx.sv
// Snapshots six ASCII distance digits and sends "dddddd" "cm" CR LF over 8N1
// whenever the digits change or a send is forced.
module length_uart_tx
    import length_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_HZ / BAUD,
    parameter int LZ_BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_ascii_0,
    input  logic [7:0] data_ascii_1,
    input  logic [7:0] data_ascii_2,
    input  logic [7:0] data_ascii_3,
    input  logic [7:0] data_ascii_4,
    input  logic [7:0] data_ascii_5,
    input  logic       force_i,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    frame_state_e state_q;
    logic [NUM_DIGITS-1:0][7:0] din;
    logic [NUM_DIGITS-1:0][7:0] snap_q;
    logic [NUM_DIGITS-1:0][7:0] buf_q;
    logic [NUM_DIGITS-1:0][7:0] dig;
    logic [3:0] idx_q;
    logic       fpend_q;
    logic       start_q;
    logic       busy_q;
    logic       frame_done_q;
    logic       trigger;
    logic       lead;
    logic [7:0] byte_c;
    logic       tx_ready;
    logic       tx_done;

    assign din     = {data_ascii_5, data_ascii_4, data_ascii_3,
                      data_ascii_2, data_ascii_1, data_ascii_0};
    assign trigger = (din != snap_q) || fpend_q;

    // Blanking walks from the most significant digit and stops at the first non-zero.
    always_comb begin
        dig  = '0;
        lead = (LZ_BLANK != 0);
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            dig[k] = sanitize(buf_q[k]);
            if (k != 0 && lead && dig[k] == ASCII_ZERO) dig[k] = ASCII_SPACE;
            else lead = 1'b0;
        end
    end

    always_comb begin
        case (idx_q)
            4'd6:    byte_c = ASCII_C;
            4'd7:    byte_c = ASCII_M;
            4'd8:    byte_c = ASCII_CR;
            4'd9:    byte_c = ASCII_LF;
            default: byte_c = (idx_q < 4'd6) ? dig[3'd5 - idx_q[2:0]] : ASCII_ZERO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            buf_q        <= '0;
            idx_q        <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                // DONE also accepts a trigger so back-to-back frames lose no cycle.
                ST_IDLE, ST_DONE: begin
                    if (trigger) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    snap_q  <= din;
                    buf_q   <= din;
                    idx_q   <= '0;
                    start_q <= 1'b1;
                    state_q <= ST_SEND;
                end
                ST_SEND: state_q <= ST_WAIT;
                ST_WAIT: if (tx_done) state_q <= ST_NEXT;
                ST_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        start_q <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A force landing in the LOAD cycle still earns its own frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     fpend_q <= 1'b0;
        else if (force_i)            fpend_q <= 1'b1;
        else if (state_q == ST_LOAD) fpend_q <= 1'b0;
    end

    uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_byte_tx (
        .clk   (clk),
        .rst   (rst),
        .start (start_q & tx_ready),
        .data  (byte_c),
        .txd   (txd),
        .ready (tx_ready),
        .done  (tx_done)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
